// File: rtl/fetch_stage_pkg.sv
// Shared instruction-type package for the fetch stage: opcodes, NOP, reset PC and IF/ID payload.
// Imported by fetch_stage, if_id_reg and benches.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic        valid;
    logic        misalign;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{
    valid:    1'b0,
    misalign: 1'b0,
    instr:    NOP_INSTR,
    pc:       32'h0000_0000,
    pc_plus4: 32'h0000_0004
  };

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;  // wraps modulo 2^32
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: pipeline control, instruction-memory handshake and IF/ID outputs.
// master = fetch_stage side, slave = pipeline/memory environment side.
interface fetch_stage_if;

  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;
  logic        id_misalign_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o,
    output id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_misalign_o
  );

  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o,
    input  id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_misalign_o
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear beats load beats flush; held while hold is set, else drains to a bubble.
// Latency: one cycle from load to output.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   load,
  input  if_id_t load_dat,
  input  logic   flush,
  input  logic   hold,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= IF_ID_RESET;
    end else if (clr) begin
      q.valid    <= 1'b0;
      q.misalign <= 1'b0;
      q.instr    <= NOP_INSTR;
    end else if (load) begin
      q <= load_dat;
    end else if (flush || !hold) begin
      // decode consumed the entry (or it was flushed): present a bubble
      q.valid    <= 1'b0;
      q.misalign <= 1'b0;
      q.instr    <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, one-entry hold buffer under stall, redirect/drop handling.
// Optional FETCH_MISALIGN_CHK_EN turns misaligned redirects into a trap entry instead of a fetch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic        req_q;
  logic [31:0] redir_pc;
  logic        misalign;
  logic        trap_q;
  logic        outstanding;
  logic        take_rsp;
  logic        release_hold;
  logic        id_clr;
  logic        id_load;
  if_id_t      load_dat;
  if_id_t      id_q;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_pc = bus.redirect_pc_i;
  assign misalign = |bus.redirect_pc_i[1:0];

  // sticky until the next redirect: no fetching while the trap entry is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              trap_q <= 1'b0;
    else if (bus.redirect_i) trap_q <= misalign;
  end
`else
  assign redir_pc = bus.redirect_pc_i & ~32'd3;
  assign misalign = 1'b0;
  assign trap_q   = 1'b0;
`endif

  assign take_rsp     = (state_q == S_WAIT) && bus.imem_rvalid_i && (!bus.stall_i || !id_q.valid);
  assign release_hold = (state_q == S_HOLD) && !bus.stall_i;

  // a response is still owed by memory after this edge
  assign outstanding = ((state_q == S_REQ) && bus.imem_ready_i)
                    || (((state_q == S_WAIT) || (state_q == S_DROP)) && !bus.imem_rvalid_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
      req_q   <= 1'b0;
    end else if (bus.redirect_i) begin
      pc_q <= redir_pc;
      if (outstanding) begin
        state_q <= S_DROP;
        req_q   <= 1'b0;
      end else if (misalign) begin
        state_q <= S_IDLE;
        req_q   <= 1'b0;
      end else begin
        state_q <= S_REQ;
        req_q   <= 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!trap_q) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.imem_ready_i) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (take_rsp) begin
            pc_q    <= pc_inc(pc_q);
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end else if (bus.imem_rvalid_i) begin
            buf_q   <= bus.imem_rdata_i;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (release_hold) begin
            pc_q    <= pc_inc(pc_q);
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_DROP: begin
          if (bus.imem_rvalid_i) begin
            state_q <= trap_q ? S_IDLE : S_REQ;
            req_q   <= !trap_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // a misaligned redirect loads a trap entry; an aligned one just clears IF/ID
  assign id_clr  = bus.redirect_i && !misalign;
  assign id_load = bus.redirect_i ? misalign : (take_rsp || release_hold);

  always_comb begin
    load_dat       = IF_ID_RESET;
    load_dat.valid = 1'b1;
    if (bus.redirect_i) begin
      load_dat.misalign = 1'b1;
      load_dat.instr    = NOP_INSTR;
      load_dat.pc       = redir_pc;
      load_dat.pc_plus4 = pc_inc(redir_pc);
    end else begin
      load_dat.misalign = 1'b0;
      load_dat.instr    = (state_q == S_HOLD) ? buf_q : bus.imem_rdata_i;
      load_dat.pc       = pc_q;
      load_dat.pc_plus4 = pc_inc(pc_q);
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (id_clr),
    .load     (id_load),
    .load_dat (load_dat),
    .flush    (bus.flush_i),
    .hold     (bus.stall_i || trap_q),
    .q        (id_q)
  );

  assign bus.imem_req_o    = req_q;
  assign bus.imem_addr_o   = pc_q;
  assign bus.id_valid_o    = id_q.valid;
  assign bus.id_instr_o    = id_q.instr;
  assign bus.id_pc_o       = id_q.pc;
  assign bus.id_pc_plus4_o = id_q.pc_plus4;
  assign bus.id_misalign_o = id_q.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then random stall/ready/latency/redirect traffic
// checked against a transaction-level model of request addresses and the consumed instruction stream.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] instr, input logic [31:0] pc);
    chk1({tag, "_valid"}, bus.id_valid_o, v);
    chk32({tag, "_instr"}, bus.id_instr_o, instr);
    chk32({tag, "_pc"}, bus.id_pc_o, pc);
    chk32({tag, "_pc4"}, bus.id_pc_plus4_o, pc + 32'd4);
  endtask

  task automatic quiet_inputs();
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  // random-phase model state
  logic [31:0] exp_req, exp_con, pend_addr, tgt, p_pc, p_instr;
  logic        pend, p_hold, stall, ready, redir;
  int          lat, ncons;

  initial begin
    quiet_inputs();
    rst_n = 1'b0;
    repeat (2) cyc();

    // reset values
    chk1 ("rst_req", bus.imem_req_o, 1'b0);
    chk32("rst_addr", bus.imem_addr_o, RPC);
    chk_id("rst_id", 1'b0, NOP_INSTR, 32'h0);
    chk1 ("rst_misalign", bus.id_misalign_o, 1'b0);

    // first fetch
    rst_n = 1'b1;
    cyc();
    chk1 ("first_req", bus.imem_req_o, 1'b1);
    chk32("first_addr", bus.imem_addr_o, RPC);
    bus.imem_ready_i = 1'b1;
    cyc();
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0050_0093;
    chk1("wait_no_req", bus.imem_req_o, 1'b0);
    cyc();
    bus.imem_rvalid_i = 1'b0;
    chk_id("fetch0", 1'b1, 32'h0050_0093, 32'h0);
    chk1 ("fetch0_req", bus.imem_req_o, 1'b1);
    chk32("fetch0_next_addr", bus.imem_addr_o, 32'h4);

    // stall while a response arrives: word parks in the hold buffer
    bus.stall_i      = 1'b1;
    bus.imem_ready_i = 1'b1;
    cyc();
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h00A0_0113;
    chk_id("stall_wait", 1'b1, 32'h0050_0093, 32'h0);
    cyc();
    bus.imem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_id("stall_hold", 1'b1, 32'h0050_0093, 32'h0);
      chk1("stall_no_req", bus.imem_req_o, 1'b0);
      cyc();
    end
    bus.stall_i = 1'b0;
    cyc();
    chk_id("hold_release", 1'b1, 32'h00A0_0113, 32'h4);
    chk1 ("hold_release_req", bus.imem_req_o, 1'b1);
    chk32("hold_release_addr", bus.imem_addr_o, 32'h8);

    // redirect while waiting: stale response dropped
    bus.imem_ready_i = 1'b1;
    cyc();
    bus.imem_ready_i  = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    cyc();
    bus.redirect_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    chk1 ("drop_valid", bus.id_valid_o, 1'b0);
    chk32("drop_instr", bus.id_instr_o, NOP_INSTR);
    chk1 ("drop_no_req", bus.imem_req_o, 1'b0);
    cyc();
    bus.imem_rvalid_i = 1'b0;
    chk1 ("after_drop_valid", bus.id_valid_o, 1'b0);
    chk1 ("after_drop_req", bus.imem_req_o, 1'b1);
    chk32("after_drop_addr", bus.imem_addr_o, 32'h100);
    bus.imem_ready_i = 1'b1;
    cyc();
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0011_0113;
    cyc();
    bus.imem_rvalid_i = 1'b0;
    chk_id("redir_fetch", 1'b1, 32'h0011_0113, 32'h100);
    chk32("redir_next_addr", bus.imem_addr_o, 32'h104);

    // PC wrap
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_i = 1'b0;
    chk32("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    chk1 ("wrap_req", bus.imem_req_o, 1'b1);
    chk1 ("wrap_cleared", bus.id_valid_o, 1'b0);
    bus.imem_ready_i = 1'b1;
    cyc();
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0020_0193;
    cyc();
    bus.imem_rvalid_i = 1'b0;
    chk32("wrap_id_pc", bus.id_pc_o, 32'hFFFF_FFFC);
    chk32("wrap_pc4", bus.id_pc_plus4_o, 32'h0);
    chk32("wrap_next_addr", bus.imem_addr_o, 32'h0);

    // misaligned redirect
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h102;
    cyc();
    bus.redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk1 ("mis_no_req", bus.imem_req_o, 1'b0);
    chk1 ("mis_flag", bus.id_misalign_o, 1'b1);
    chk_id("mis_trap", 1'b1, NOP_INSTR, 32'h102);
    cyc();
    chk1 ("mis_stay_idle", bus.imem_req_o, 1'b0);
    chk1 ("mis_stay_flag", bus.id_misalign_o, 1'b1);
`else
    chk1 ("mis_req", bus.imem_req_o, 1'b1);
    chk32("mis_addr_forced", bus.imem_addr_o, 32'h100);
    chk1 ("mis_flag_tied", bus.id_misalign_o, 1'b0);
`endif
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    cyc();
    bus.redirect_i = 1'b0;
    chk1 ("realign_req", bus.imem_req_o, 1'b1);
    chk32("realign_addr", bus.imem_addr_o, 32'h100);
    chk1 ("realign_flag", bus.id_misalign_o, 1'b0);

    // flush: same-cycle response still loads, flush beats stall
    bus.imem_ready_i = 1'b1;
    cyc();
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0030_0213;
    cyc();
    bus.imem_rvalid_i = 1'b0;
    chk_id("pre_flush", 1'b1, 32'h0030_0213, 32'h100);
    bus.stall_i      = 1'b1;
    bus.imem_ready_i = 1'b1;
    cyc();
    bus.imem_ready_i = 1'b0;
    chk_id("pre_flush_hold", 1'b1, 32'h0030_0213, 32'h100);
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b1;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0040_0293;
    cyc();
    bus.imem_rvalid_i = 1'b0;
    chk_id("flush_load_wins", 1'b1, 32'h0040_0293, 32'h104);
    bus.stall_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    chk1 ("flush_valid", bus.id_valid_o, 1'b0);
    chk32("flush_instr", bus.id_instr_o, NOP_INSTR);
    chk32("flush_pc_kept", bus.imem_addr_o, 32'h108);

    // asynchronous reset mid-transaction
    bus.imem_ready_i = 1'b1;
    cyc();
    bus.imem_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1 ("arst_req", bus.imem_req_o, 1'b0);
    chk32("arst_addr", bus.imem_addr_o, RPC);
    chk_id("arst_id", 1'b0, NOP_INSTR, 32'h0);
    cyc();
    rst_n = 1'b1;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hBAD0_BAD0;
    cyc();
    bus.imem_rvalid_i = 1'b0;
    chk1 ("post_rst_req", bus.imem_req_o, 1'b1);
    chk32("post_rst_addr", bus.imem_addr_o, RPC);
    chk1 ("post_rst_stale", bus.id_valid_o, 1'b0);
    bus.imem_ready_i = 1'b1;
    cyc();
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0050_0313;
    cyc();
    bus.imem_rvalid_i = 1'b0;
    chk_id("post_rst_fetch", 1'b1, 32'h0050_0313, RPC);

    // random traffic against the transaction model
    quiet_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n   = 1'b1;
    exp_req = RPC;
    exp_con = RPC;
    pend    = 1'b0;
    pend_addr = 32'h0;
    lat     = 0;
    ncons   = 0;
    p_hold  = 1'b0;
    p_pc    = 32'h0;
    p_instr = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      if (p_hold) begin
        chk1 ("rnd_hold_valid", bus.id_valid_o, 1'b1);
        chk32("rnd_hold_pc", bus.id_pc_o, p_pc);
        chk32("rnd_hold_instr", bus.id_instr_o, p_instr);
      end
      if (!bus.id_valid_o) chk32("rnd_bubble_nop", bus.id_instr_o, NOP_INSTR);
      if (bus.imem_req_o) chk1("rnd_single_outstanding", pend, 1'b0);

      stall = ($urandom_range(0, 2) == 0);
      ready = ($urandom_range(0, 1) == 1);
      redir = ($urandom_range(0, 19) == 0);
      tgt   = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);

      bus.imem_rvalid_i = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          bus.imem_rvalid_i = 1'b1;
          bus.imem_rdata_i  = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          lat--;
        end
      end

      if (bus.id_valid_o && !stall && !redir) begin
        chk32("rnd_con_pc", bus.id_pc_o, exp_con);
        chk32("rnd_con_instr", bus.id_instr_o, mem_word(exp_con));
        chk32("rnd_con_pc4", bus.id_pc_plus4_o, exp_con + 32'd4);
        exp_con = exp_con + 32'd4;
        ncons++;
      end
      if (bus.imem_req_o && ready) begin
        chk32("rnd_req_addr", bus.imem_addr_o, exp_req);
        exp_req   = exp_req + 32'd4;
        pend      = 1'b1;
        pend_addr = bus.imem_addr_o;
        lat       = $urandom_range(0, 3);
      end
      if (redir) begin
        exp_req = tgt;
        exp_con = tgt;
      end

      p_hold  = bus.id_valid_o && stall && !redir;
      p_pc    = bus.id_pc_o;
      p_instr = bus.id_instr_o;

      bus.stall_i       = stall;
      bus.imem_ready_i  = ready;
      bus.redirect_i    = redir;
      bus.redirect_pc_i = tgt;
      cyc();
    end
    chk1("rnd_enough_traffic", (ncons > 100), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stall_i  input  1  decode cannot accept; hold the IF/ID register.
REQ-006 flush_i  input  1  invalidate the IF/ID register; no PC change.
REQ-007 redirect_i  input  1  branch/jump taken; load redirect_pc_i.
REQ-008 redirect_pc_i  input  32  redirect target.
REQ-009 imem_req_o  output  1  fetch request.
REQ-010 imem_addr_o  output  32  fetch address (word-aligned).
REQ-011 imem_ready_i  input  1  memory accepts the request this cycle.
REQ-012 imem_rvalid_i  input  1  response data valid.
REQ-013 imem_rdata_i  input  32  fetched instruction.
REQ-014 id_valid_o  output  1  IF/ID holds a valid instruction.
REQ-015 id_instr_o  output  32  instruction to the decoder/immediate extender.
REQ-016 id_pc_o  output  32  PC of id_instr_o.
REQ-017 id_pc_plus4_o  output  32  id_pc_o + 4, modulo 2^32.
REQ-018 id_misalign_o  output  1  misaligned redirect trap flag (see Configuration).

Function
REQ-019 SHALL use states IDLE, REQ, WAIT, HOLD, DROP; at most one request SHALL be outstanding.
REQ-020 IDLE: imem_req_o=0; SHALL move to REQ on the first cycle after reset release.
REQ-021 REQ: imem_req_o=1 and imem_addr_o=pc; on imem_ready_i SHALL go to WAIT. Otherwise it SHALL stay in REQ with the address stable.
REQ-022 WAIT with imem_rvalid_i and (!stall_i or !id_valid_o): SHALL load IF/ID {valid=1, instr=rdata, pc}, set pc=pc+4, and go to REQ.
REQ-023 WAIT with imem_rvalid_i while stall_i and id_valid_o: SHALL capture rdata into a one-entry hold buffer and go to HOLD.
REQ-024 HOLD: when stall_i deasserts, the buffer SHALL move into IF/ID, pc SHALL become pc+4, and the FSM SHALL go to REQ; no request is issued in HOLD.
REQ-025 While stall_i and id_valid_o, the IF/ID register SHALL be held unchanged.
REQ-026 Redirect SHALL have priority over stall and normal flow: pc=redirect_pc_i, id_valid_o cleared next cycle, hold buffer discarded.
REQ-027 Redirect in WAIT without same-cycle rvalid, or in REQ with same-cycle imem_ready_i: SHALL go to DROP.
REQ-028 Redirect in any other state, including WAIT with same-cycle rvalid: SHALL discard the response and go to REQ.
REQ-029 DROP: SHALL discard the next imem_rvalid_i response, then go to REQ; a redirect in DROP SHALL only update pc.
REQ-030 flush_i SHALL clear id_valid_o and load id_instr_o=NOP (32'h0000_0013) next cycle; a same-cycle WAIT response SHALL still load normally.
REQ-031 When id_valid_o=0, id_instr_o SHALL be NOP.
REQ-032 PC arithmetic SHALL be 32-bit wrapping: 32'hFFFF_FFFC+4 = 32'h0.
REQ-033 Fetch-to-IF/ID latency SHALL be one cycle after imem_rvalid_i when not stalled.

Reset
REQ-034 While rst_n=0, outputs SHALL be: imem_req_o=0, imem_addr_o=RESET_PC, id_valid_o=0, id_instr_o=NOP, id_pc_o=0, id_pc_plus4_o=4, id_misalign_o=0; FSM=IDLE, pc=RESET_PC.
REQ-035 Reset asserted mid-transaction SHALL abandon the outstanding request; after release, the first response SHALL belong to the new RESET_PC request.

Configuration
REQ-036 Macro FETCH_MISALIGN_CHK_EN: when defined, a redirect with redirect_pc_i[1:0]!=0 SHALL issue no fetch. The block SHALL then present id_valid_o=1, id_misalign_o=1, id_instr_o=NOP, id_pc_o=target, and stay idle until the next redirect.
REQ-037 Without FETCH_MISALIGN_CHK_EN, id_misalign_o SHALL be tied 0 and redirect_pc_i[1:0] SHALL be forced to 0.

Structure
REQ-038 The NOP constant and RESET_PC default SHALL live in the shared instruction-type package beside the opcode constants; the FSM state enum SHALL stay local.
REQ-039 The IF/ID register (valid/instr/pc/pc_plus4 with hold and flush) SHALL be a sub-module if_id_reg.

Verification
REQ-040 Reset release, ready=1, rvalid one cycle later with rdata 32'h00500093 -> IF/ID valid, instr=32'h00500093, pc=0, pc_plus4=4; next imem_addr_o=4.
REQ-041 stall_i held 3 cycles while a response arrives -> IF/ID unchanged, FSM in HOLD; after release IF/ID takes the held word, then a request is issued to pc+4.
REQ-042 Redirect to 32'h100 while in WAIT, stale rvalid next cycle -> stale word dropped; next request address = 32'h100; id_valid_o=0 in between.
REQ-043 pc=32'hFFFF_FFFC fetch -> id_pc_plus4_o=0, next imem_addr_o=0.
REQ-044 With FETCH_MISALIGN_CHK_EN, redirect to 32'h102 -> no imem_req_o, id_misalign_o=1, id_pc_o=32'h102; without the macro the next fetch is at 32'h100.
REQ-045 rst_n pulsed low during WAIT -> outputs at reset values asynchronously; the first post-reset request is at RESET_PC.
